// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clock edges and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      data_q, data_d;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            dat_meta_q, dat_sync_q;
  logic            fall;
  logic [2:0]      bit_idx;

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign bit_idx = bitcnt_q[2:0] - 3'd1;

  // Synchronizers idle high, matching the pulled-up bus at rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      data_q     <= '0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      data_q     <= data_d;
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (send) begin
          data_d   = data_in;
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) state_d = S_REQ;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_REQ: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = S_XFER;
      end
      S_XFER: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TMO_LAST) begin
          state_d = S_ERR;
        end else if (fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          // Eleventh fall: device pulls data low to acknowledge.
          if (bitcnt_q == 4'd10) state_d = dat_sync_q ? S_ERR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TMO_LAST)             state_d = S_ERR;
        else if (clk_sync_q && dat_sync_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      S_INHIBIT: ps2_clk_oe = 1'b1;
      S_REQ: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
      end
      S_XFER: begin
        // Start bit stays driven until the device's first falling edge.
        if (bitcnt_q == 4'd0)       ps2_dat_oe = 1'b1;
        else if (bitcnt_q <= 4'd8)  ps2_dat_oe = ~data_q[bit_idx];
        else if (bitcnt_q == 4'd9)  ps2_dat_oe = ^data_q;
      end
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and every observed bit, pulse and timing is compared to hand values.
module tb_ps2_host_tx;

  localparam int HALF = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // Main instance
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_pad, ps2_dat_pad;
  logic       clk_oe, dat_oe, busy, done, error;
  assign ps2_clk_pad = dev_clk & ~clk_oe;
  assign ps2_dat_pad = dev_dat & ~dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(5000)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .send(send),
    .ps2_clk(ps2_clk_pad), .ps2_dat(ps2_dat_pad),
    .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe),
    .busy(busy), .done(done), .error(error)
  );

  // Short-timeout instance
  logic [7:0] to_data_in = 8'h00;
  logic       to_send = 1'b0;
  logic       to_dev_clk = 1'b1, to_dev_dat = 1'b1;
  logic       to_clk_pad, to_dat_pad;
  logic       to_clk_oe, to_dat_oe, to_busy, to_done, to_error;
  assign to_clk_pad = to_dev_clk & ~to_clk_oe;
  assign to_dat_pad = to_dev_dat & ~to_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut_to (
    .clk(clk), .rst(rst), .data_in(to_data_in), .send(to_send),
    .ps2_clk(to_clk_pad), .ps2_dat(to_dat_pad),
    .ps2_clk_oe(to_clk_oe), .ps2_dat_oe(to_dat_oe),
    .busy(to_busy), .done(to_done), .error(to_error)
  );

  int done_cyc = 0, err_cyc = 0, to_done_cyc = 0, to_err_cyc = 0;
  always @(negedge clk) begin
    if (done)     done_cyc++;
    if (error)    err_cyc++;
    if (to_done)  to_done_cyc++;
    if (to_error) to_err_cyc++;
  end

  int checks = 0;
  int errors = 0;

  initial begin
    #800000;
    $display("FAIL watchdog: got no summary by %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_send(input logic [7:0] b);
    data_in = b;
    send    = 1'b1;
    cyc(1);
    send    = 1'b0;
  endtask

  // Device model: measures the inhibit, checks the request, clocks 11 falls,
  // samples each host bit late in the low half and answers with ack_bit.
  task automatic device_frame(input logic ack_bit, output logic [9:0] bits,
                              output int inh_len, output logic req_ok, output logic tmo);
    int guard;
    bits = '0; inh_len = 0; req_ok = 1'b0; tmo = 1'b0; guard = 0;
    while (!clk_oe && guard < 100) begin cyc(1); guard++; end
    if (!clk_oe) begin tmo = 1'b1; return; end
    while (clk_oe && !dat_oe && inh_len < 10000) begin inh_len++; cyc(1); end
    req_ok = clk_oe && dat_oe;
    cyc(1);
    req_ok = req_ok && !clk_oe && dat_oe;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b1;
      cyc(HALF / 2);
      if (k == 11) dev_dat = ack_bit;
      cyc(HALF / 2);
      dev_clk = 1'b0;
      cyc(HALF);
      if (k <= 10) bits[k-1] = ps2_dat_pad;
    end
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({clk_oe, dat_oe, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held: got %b expected 00000", {clk_oe, dat_oe, busy, done, error});
    end
    rst = 1'b0;
    cyc(2);
    checks++;
    if ({clk_oe, dat_oe, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_released: got %b expected 00000", {clk_oe, dat_oe, busy, done, error});
    end
    checks++;
    if ({to_clk_oe, to_dat_oe, to_busy, to_done, to_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_to_inst: got %b expected 00000",
               {to_clk_oe, to_dat_oe, to_busy, to_done, to_error});
    end
  endtask

  task automatic test_frame_ed();
    logic [9:0] bits; int inh; logic req_ok, tmo; int d0;
    d0 = done_cyc;
    do_send(8'hED);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ed_busy_rise: got %b expected 1", busy); end
    device_frame(1'b0, bits, inh, req_ok, tmo);
    cyc(20);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL ed_no_request: got %b expected 0", tmo); end
    checks++;
    if (inh !== 20) begin errors++; $display("FAIL ed_inhibit_len: got %0d expected 20", inh); end
    checks++;
    if (req_ok !== 1'b1) begin errors++; $display("FAIL ed_start_bit: got %b expected 1", req_ok); end
    checks++;
    if (bits !== 10'b11_1110_1101) begin
      errors++; $display("FAIL ed_bits: got %b expected 1111101101", bits);
    end
    checks++;
    if (done_cyc - d0 !== 1) begin errors++; $display("FAIL ed_done_count: got %0d expected 1", done_cyc - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ed_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_frame_f4();
    logic [9:0] bits; int inh; logic req_ok, tmo; int d0;
    d0 = done_cyc;
    do_send(8'hF4);
    device_frame(1'b0, bits, inh, req_ok, tmo);
    cyc(20);
    checks++;
    if (bits[8] !== 1'b0) begin errors++; $display("FAIL f4_parity: got %b expected 0", bits[8]); end
    checks++;
    if (bits !== 10'b10_1111_0100) begin
      errors++; $display("FAIL f4_bits: got %b expected 1011110100", bits);
    end
    checks++;
    if (done_cyc - d0 !== 1) begin errors++; $display("FAIL f4_done: got %0d expected 1", done_cyc - d0); end
  endtask

  task automatic test_nack();
    logic [9:0] bits; int inh; logic req_ok, tmo; int d0, e0;
    d0 = done_cyc; e0 = err_cyc;
    do_send(8'hFF);
    device_frame(1'b1, bits, inh, req_ok, tmo);
    cyc(20);
    checks++;
    if (bits !== 10'b11_1111_1111) begin
      errors++; $display("FAIL ff_bits: got %b expected 1111111111", bits);
    end
    checks++;
    if (err_cyc - e0 !== 1) begin errors++; $display("FAIL nack_error_cycles: got %0d expected 1", err_cyc - e0); end
    checks++;
    if (done_cyc - d0 !== 0) begin errors++; $display("FAIL nack_done: got %0d expected 0", done_cyc - d0); end
    checks++;
    if ({clk_oe, dat_oe} !== 2'b00) begin errors++; $display("FAIL nack_lines: got %b expected 00", {clk_oe, dat_oe}); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int guard, t_rel, t_err, e0, d0;
    e0 = to_err_cyc; d0 = to_done_cyc; guard = 0;
    to_data_in = 8'h00;
    to_send = 1'b1;
    cyc(1);
    to_send = 1'b0;
    while (to_clk_oe && guard < 200) begin cyc(1); guard++; end
    t_rel = cycle;
    checks++;
    if (to_clk_oe !== 1'b0) begin errors++; $display("FAIL to_release: got %b expected 0", to_clk_oe); end
    for (int k = 0; k < 4; k++) begin
      to_dev_clk = 1'b1; cyc(20);
      to_dev_clk = 1'b0; cyc(20);
    end
    to_dev_clk = 1'b1;
    guard = 0;
    while (!to_error && guard < 1000) begin cyc(1); guard++; end
    t_err = cycle;
    checks++;
    if (to_error !== 1'b1 || (t_err - t_rel) < 497 || (t_err - t_rel) > 502) begin
      errors++;
      $display("FAIL to_latency: got %0d (error=%b) expected 497..502", t_err - t_rel, to_error);
    end
    cyc(3);
    checks++;
    if (to_err_cyc - e0 !== 1) begin errors++; $display("FAIL to_error_cycles: got %0d expected 1", to_err_cyc - e0); end
    checks++;
    if (to_done_cyc - d0 !== 0) begin errors++; $display("FAIL to_done: got %0d expected 0", to_done_cyc - d0); end
    checks++;
    if ({to_clk_oe, to_dat_oe, to_busy} !== 3'b000) begin
      errors++; $display("FAIL to_lines: got %b expected 000", {to_clk_oe, to_dat_oe, to_busy});
    end
  endtask

  task automatic test_busy_ignore();
    logic [9:0] bits; int inh; logic req_ok, tmo; int d0;
    d0 = done_cyc;
    do_send(8'h3C);
    fork
      device_frame(1'b0, bits, inh, req_ok, tmo);
      begin
        cyc(10);
        data_in = 8'hAA; send = 1'b1; cyc(1); send = 1'b0;
        cyc(600);
        data_in = 8'hAA; send = 1'b1; cyc(1); send = 1'b0;
      end
    join
    cyc(20);
    checks++;
    if (inh !== 20) begin errors++; $display("FAIL ign_inhibit_len: got %0d expected 20", inh); end
    checks++;
    if (bits !== 10'b11_0011_1100) begin
      errors++; $display("FAIL ign_bits: got %b expected 1100111100", bits);
    end
    checks++;
    if (done_cyc - d0 !== 1) begin errors++; $display("FAIL ign_done: got %0d expected 1", done_cyc - d0); end
    cyc(50);
    checks++;
    if ({clk_oe, busy} !== 2'b00) begin errors++; $display("FAIL ign_no_second_frame: got %b expected 00", {clk_oe, busy}); end
  endtask

  task automatic test_reset_mid_frame();
    int guard, d0, e0;
    d0 = done_cyc; e0 = err_cyc; guard = 0;
    do_send(8'h55);
    while (clk_oe && guard < 100) begin cyc(1); guard++; end
    cyc(5);
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b011) begin
      errors++; $display("FAIL mid_xfer_state: got %b expected 011", {clk_oe, dat_oe, busy});
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_release: got %b expected 000", {clk_oe, dat_oe, busy});
    end
    cyc(3);
    rst = 1'b0;
    cyc(10);
    checks++;
    if (done_cyc - d0 !== 0) begin errors++; $display("FAIL mid_reset_done: got %0d expected 0", done_cyc - d0); end
    checks++;
    if (err_cyc - e0 !== 0) begin errors++; $display("FAIL mid_reset_error: got %0d expected 0", err_cyc - e0); end
    checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_after: got %b expected 000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits1, bits2; int inh; logic req_ok, tmo; int d0, guard;
    d0 = done_cyc;
    do_send(8'hED);
    device_frame(1'b0, bits1, inh, req_ok, tmo);
    guard = 0;
    while (!done && guard < 50) begin cyc(1); guard++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", done); end
    // A request landing in the DONE cycle must be dropped.
    data_in = 8'h77; send = 1'b1; cyc(1); send = 1'b0;
    checks++;
    if ({busy, clk_oe} !== 2'b00) begin
      errors++; $display("FAIL b2b_gap_busy: got %b expected 00", {busy, clk_oe});
    end
    do_send(8'h02);
    device_frame(1'b0, bits2, inh, req_ok, tmo);
    cyc(20);
    checks++;
    if (bits1 !== 10'b11_1110_1101) begin
      errors++; $display("FAIL b2b_bits_ed: got %b expected 1111101101", bits1);
    end
    checks++;
    if (bits2 !== 10'b10_0000_0010) begin
      errors++; $display("FAIL b2b_bits_02: got %b expected 1000000010", bits2);
    end
    checks++;
    if (done_cyc - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cyc - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_frame_f4();
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
